icache_line_buffer: RTL
=======================

# icache_line_buffer

Parametrised fetch-side line buffer between the fetch stage and the instruction cache. It holds up to `ENTRIES` recently fetched cache lines, fully associative with round-robin replacement, and serves hits combinationally. On a miss it issues one outstanding icache request through a two-state FSM, and it kills, flushes and forwards translation exceptions. It generalises the single-line buffer in line width, address width and entry count, and adds multi-line retention.

## Interface
- `ADDR_W`, 40, virtual address width.
- `LINE_W`, 128, cache line width in bits; power of two, at least `INST_W`.
- `INST_W`, 32, instruction width.
- `ENTRIES`, 4, buffered lines; power of two, at least 1.
- `IDX_W`, 12, icache index width; VPN width is `ADDR_W-IDX_W`.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rstn_i` in 1: reset, synchronous, active-low.
- `fetch_valid_i` in 1: fetch request valid.
- `fetch_vaddr_i` in `ADDR_W`: fetch PC.
- `fetch_kill_i` in 1: abandon outstanding request.
- `fetch_inv_icache_i` in 1: invalidate icache; forwarded.
- `fetch_inv_buffer_i` in 1: flush all buffer entries.
- `icache_req_ready_i` in 1: icache can accept a request.
- `icache_resp_valid_i` in 1: response valid.
- `icache_resp_vaddr_i` in `ADDR_W`: address of the returned line.
- `icache_resp_data_i` in `LINE_W`: line data.
- `tlb_xcp_i` in 1: translation exception for the current fetch.
- `icache_req_valid_o` out 1: request strobe.
- `icache_req_idx_o` out `IDX_W`: `vaddr[IDX_W-1:0]`.
- `icache_req_vpn_o` out `ADDR_W-IDX_W`: `vaddr[ADDR_W-1:IDX_W]`.
- `icache_req_kill_o` out 1: kill to icache.
- `icache_invalidate_o` out 1: equals `fetch_inv_icache_i`.
- `resp_valid_o` out 1: instruction available this cycle.
- `resp_inst_o` out `INST_W`: selected instruction.
- `resp_xcp_o` out 1: fetch exception.
- `miss_o` out 1: valid fetch missed the buffer.

## Operation
- `OFF_W = log2(LINE_W/8)`.
- Line tag is `vaddr[ADDR_W-1:OFF_W]`.
- Word select is `vaddr[OFF_W-1:log2(INST_W/8)]`.
- Each entry holds a valid bit, a tag and data.
- Hit: `fetch_valid_i` and any valid entry's tag matches. At most one entry matches, so the hit is one-hot.
- `miss_o = fetch_valid_i & ~hit`.
- `do_req = miss_o & ~fetch_inv_buffer_i & icache_req_ready_i`.
- Request address mux:
  - `do_req` high in IDLE: address comes from `fetch_vaddr_i`.
  - Otherwise: address comes from the latched `req_addr_q`.
- FSM states: IDLE (reset) and WAIT.
- In IDLE:
  - `icache_req_valid_o = do_req`.
  - Move to WAIT on `do_req & ~tlb_xcp_i`; `req_addr_q` captures `fetch_vaddr_i` at that point.
- In WAIT:
  - `icache_req_valid_o = 0`.
  - Return to IDLE on any of: `resp_ok`, `fetch_kill_i`, `fetch_inv_icache_i`, or a fetch line tag different from `req_addr_q`'s tag (redirect).
  - On redirect, `icache_req_kill_o` is asserted that cycle.
- `resp_ok = icache_resp_valid_i & ~tlb_xcp_i & (resp tag == fetch tag)`.
  - On `resp_ok` the line is written into entry `rr_ptr` and `rr_ptr` increments modulo `ENTRIES`.
  - The same cycle, the instruction is bypassed from `icache_resp_data_i`.
- Responses with a mismatched tag are dropped; no write, no pointer change.
- `fetch_inv_buffer_i` clears all valid bits next cycle and takes precedence over a same-cycle fill (no write). `rr_ptr` is unchanged.
- `resp_valid_o`:
  - `hit | resp_ok` in WAIT.
  - `hit | (tlb_xcp_i & do_req)` in IDLE.
- `resp_xcp_o = tlb_xcp_i & miss_o`. When it is set, `resp_inst_o` is 0.
- `icache_req_kill_o = fetch_kill_i | (WAIT & redirect)`.
- Reset values: all valid bits 0, `rr_ptr` 0, state IDLE, `req_addr_q` 0.

## Timing
- Buffer hit: zero-cycle latency; outputs combinational from the current fetch.
- Miss: request in cycle N.
  - Earliest instruction delivery is cycle N+1 via bypass.
  - The entry is readable as a hit from the cycle after the fill.
- One outstanding request only; no new request is issued while in WAIT.
- Reset asserted mid-WAIT: next cycle is IDLE with all entries invalid. Any later response is dropped unless its tag matches a new request.
- Wrap-around: after `ENTRIES` fills, the oldest entry is overwritten.
- Simultaneous `resp_ok` and `fetch_kill_i`: return to IDLE, fill still performed.

## Structure
- Shared package `icache_buf_pkg`:
  - FSM state enum (IDLE, WAIT).
  - Entry struct (valid, tag, data).
  - Derived widths `OFF_W`, `WSEL_W`.
  - Default parameter constants.
- Sub-module `line_buffer_array`:
  - Tag compare and one-hot hit.
  - Write port with round-robin pointer.
  - Flush.
  - Data read mux.
- The FSM, request muxing and response select stay in the top module.

## Test plan
- Cold fetch at `0x0000001000`, ready=1:
  - Cycle 0: `icache_req_valid_o=1`, idx `0x000`, vpn `0x0000001`.
  - Response in cycle 2 with word 0 = `0xDEADBEEF`: `resp_valid_o=1`, `resp_inst_o=0xDEADBEEF`.
  - Then fetch `0x0000001004`: hit, no request.
- Fill 5 distinct lines with `ENTRIES=4`: refetch of line 0 misses; lines 1–4 hit.
- WAIT, then fetch redirects to `0x2000`: `icache_req_kill_o=1` that cycle, FSM returns to IDLE; the late response for `0x1000` is not written.
- `fetch_inv_buffer_i` pulse after 2 fills: next fetch of either line misses; `rr_ptr` continues from 2.
- Miss with `tlb_xcp_i=1`: `resp_valid_o=1`, `resp_xcp_o=1`, `resp_inst_o=0`, FSM stays IDLE.
- Reset (`rstn_i=0`) during WAIT: next cycle IDLE, `icache_req_valid_o=0`, all misses.

Source files
------------

// File: rtl/icache_buf_pkg.sv
// rtl/icache_buf_pkg.sv - shared types, default widths and width helpers for the fetch line buffer
package icache_buf_pkg;

  localparam int DEF_ADDR_W  = 40;
  localparam int DEF_LINE_W  = 128;
  localparam int DEF_INST_W  = 32;
  localparam int DEF_ENTRIES = 4;
  localparam int DEF_IDX_W   = 12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Byte-offset bits inside one cache line.
  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Word-select bits; kept at least 1 so single-word lines still have a legal index.
  function automatic int wsel_w(input int line_w, input int inst_w);
    int w;
    w = $clog2(line_w / 8) - $clog2(inst_w / 8);
    return (w > 0) ? w : 1;
  endfunction

  typedef struct packed {
    logic                                                 valid;
    logic [DEF_ADDR_W-$clog2(DEF_LINE_W/8)-1:0]           tag;
    logic [DEF_LINE_W-1:0]                                data;
  } entry_t;

endpackage

// File: rtl/line_buffer_array.sv
// rtl/line_buffer_array.sv - fully associative line store with one-hot lookup and round-robin fill
module line_buffer_array
  import icache_buf_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int INST_W  = DEF_INST_W,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int TAG_W   = DEF_ADDR_W - off_w(DEF_LINE_W),
  parameter int WSEL_W  = wsel_w(DEF_LINE_W, DEF_INST_W)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                flush_i,
  input  logic                lookup_valid_i,
  input  logic [TAG_W-1:0]    lookup_tag_i,
  input  logic [WSEL_W-1:0]   wsel_i,
  input  logic                wr_en_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [LINE_W-1:0]   wr_data_i,
  output logic                hit_o,
  output logic [ENTRIES-1:0]  hit_oh_o,
  output logic [INST_W-1:0]   rd_inst_o
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int WORDS = LINE_W / INST_W;

  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [PTR_W-1:0]               rr_q, rr_d;
  logic [TAG_W-1:0]               tag_q  [ENTRIES];
  logic [LINE_W-1:0]              data_q [ENTRIES];
  logic [LINE_W-1:0]              rd_line;
  logic [WORDS-1:0][INST_W-1:0]   rd_words;
  logic                           wr_fire;

  always_comb begin
    hit_oh_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_oh_o[i] = lookup_valid_i & valid_q[i] & (tag_q[i] == lookup_tag_i);
    end
  end

  assign hit_o = |hit_oh_o;

  // Tags are unique, so an AND-OR over the one-hot vector is a clean mux.
  always_comb begin
    rd_line = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rd_line = rd_line | ({LINE_W{hit_oh_o[i]}} & data_q[i]);
    end
  end

  assign rd_words  = rd_line;
  assign rd_inst_o = rd_words[wsel_i];

  assign wr_fire = wr_en_i & ~flush_i;

  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (wr_en_i) begin
      valid_d[rr_q] = 1'b1;
      rr_d          = (rr_q == PTR_W'(ENTRIES - 1)) ? '0 : rr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      tag_q[rr_q]  <= wr_tag_i;
      data_q[rr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache_line_buffer.sv
// rtl/icache_line_buffer.sv - fetch-side multi-line buffer with single outstanding icache request
module icache_line_buffer
  import icache_buf_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int INST_W  = DEF_INST_W,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      fetch_valid_i,
  input  logic [ADDR_W-1:0]         fetch_vaddr_i,
  input  logic                      fetch_kill_i,
  input  logic                      fetch_inv_icache_i,
  input  logic                      fetch_inv_buffer_i,
  input  logic                      icache_req_ready_i,
  input  logic                      icache_resp_valid_i,
  input  logic [ADDR_W-1:0]         icache_resp_vaddr_i,
  input  logic [LINE_W-1:0]         icache_resp_data_i,
  input  logic                      tlb_xcp_i,
  output logic                      icache_req_valid_o,
  output logic [IDX_W-1:0]          icache_req_idx_o,
  output logic [ADDR_W-IDX_W-1:0]   icache_req_vpn_o,
  output logic                      icache_req_kill_o,
  output logic                      icache_invalidate_o,
  output logic                      resp_valid_o,
  output logic [INST_W-1:0]         resp_inst_o,
  output logic                      resp_xcp_o,
  output logic                      miss_o
);

  localparam int LN_OFF_W  = off_w(LINE_W);
  localparam int IB_W      = $clog2(INST_W / 8);
  localparam int LN_WSEL_W = wsel_w(LINE_W, INST_W);
  localparam int TAG_W     = ADDR_W - LN_OFF_W;
  localparam int WORDS     = LINE_W / INST_W;

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             req_addr_q, req_addr_d, req_addr;
  logic [TAG_W-1:0]              fetch_tag, resp_tag, req_tag;
  logic [LN_WSEL_W-1:0]          wsel;
  logic                          hit, miss, do_req, redirect, resp_ok;
  logic                          req_valid, resp_valid, wait_kill;
  logic [ENTRIES-1:0]            hit_oh;
  logic [INST_W-1:0]             buf_inst, bypass_inst;
  logic [WORDS-1:0][INST_W-1:0]  resp_words;
  logic                          unused_addr_bits;

  assign fetch_tag = fetch_vaddr_i[ADDR_W-1:LN_OFF_W];
  assign resp_tag  = icache_resp_vaddr_i[ADDR_W-1:LN_OFF_W];
  assign req_tag   = req_addr_q[ADDR_W-1:LN_OFF_W];

  generate
    if (LN_OFF_W > IB_W) begin : g_wsel
      assign wsel = fetch_vaddr_i[LN_OFF_W-1:IB_W];
    end else begin : g_no_wsel
      assign wsel = '0;
    end
  endgenerate

  assign unused_addr_bits = ^{fetch_vaddr_i, icache_resp_vaddr_i};

  line_buffer_array #(
    .LINE_W  (LINE_W),
    .INST_W  (INST_W),
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .WSEL_W  (LN_WSEL_W)
  ) u_array (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .flush_i        (fetch_inv_buffer_i),
    .lookup_valid_i (fetch_valid_i),
    .lookup_tag_i   (fetch_tag),
    .wsel_i         (wsel),
    .wr_en_i        (resp_ok),
    .wr_tag_i       (resp_tag),
    .wr_data_i      (icache_resp_data_i),
    .hit_o          (hit),
    .hit_oh_o       (hit_oh),
    .rd_inst_o      (buf_inst)
  );

  assign miss     = fetch_valid_i & ~hit;
  assign do_req   = miss & ~fetch_inv_buffer_i & icache_req_ready_i;
  assign redirect = (fetch_tag != req_tag);
  assign resp_ok  = icache_resp_valid_i & ~tlb_xcp_i & (resp_tag == fetch_tag);

  assign resp_words  = icache_resp_data_i;
  assign bypass_inst = resp_words[wsel];

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_valid  = 1'b0;
    resp_valid = hit;
    wait_kill  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_valid  = do_req;
        resp_valid = hit | (tlb_xcp_i & do_req);
        if (do_req && !tlb_xcp_i) begin
          state_d    = ST_WAIT;
          req_addr_d = fetch_vaddr_i;
        end
      end
      ST_WAIT: begin
        resp_valid = hit | resp_ok;
        wait_kill  = redirect;
        if (resp_ok || fetch_kill_i || fetch_inv_icache_i || redirect) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The fresh PC goes out on the issuing cycle; afterwards the latched one is shown.
  assign req_addr = (state_q == ST_IDLE && do_req) ? fetch_vaddr_i : req_addr_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign icache_req_valid_o  = req_valid;
  assign icache_req_idx_o    = req_addr[IDX_W-1:0];
  assign icache_req_vpn_o    = req_addr[ADDR_W-1:IDX_W];
  assign icache_req_kill_o   = fetch_kill_i | wait_kill;
  assign icache_invalidate_o = fetch_inv_icache_i;
  assign resp_valid_o        = resp_valid;
  assign resp_xcp_o          = tlb_xcp_i & miss;
  assign miss_o              = miss;
  assign resp_inst_o         = resp_xcp_o ? '0 : (hit ? buf_inst : bypass_inst);

endmodule
